// File: rtl/chan_arbiter.sv
// chan_arbiter
//   Merges data blocks from NCH single-channel processors onto one 16-bit
//   stream for the board event FIFO. Channels are granted round-robin. A
//   granted channel is drained one word per ack pulse until its whole block
//   (header, optional trigger word, L data words) has been forwarded.
//
//   Block header: 1xNN_NNNN_LLLL_LLLL
//     bit14 = 1 adds one trigger word after the header.
//     L     = number of data words that follow.
//
//   Optional build macro: ARB_HDRCHK_EN
//     When defined, a header whose bit15 is 0, or whose channel field differs
//     from the granted channel, is dropped and counted in err_cnt.
//     When undefined, err_cnt is tied to 0.
//
// Ports
//   clk      in   125 MHz clock
//   reset    in   asynchronous, active-high reset
//   din      in   channel data, slice i = din[16*i+15:16*i]
//   req      in   channel i holds a complete block
//   ack      out  registered one-hot; each high cycle consumes one word of that channel
//   dout     out  merged data word
//   dvalid   out  dout valid this cycle
//   dafull   in   downstream almost full; pauses ack issue
//   busy     out  a block transfer is in progress
//   cursel   out  channel currently granted
//   err_cnt  out  header error count (saturating)
module chan_arbiter #(
    parameter int NCH = 16,
    parameter int CHW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [16*NCH-1:0] din,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    ack,
    output logic [15:0]       dout,
    output logic              dvalid,
    input  logic              dafull,
    output logic              busy,
    output logic [CHW-1:0]    cursel,
    output logic [15:0]       err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACKH, S_WAITH, S_HDR, S_COPY, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CHW-1:0] cursel_q, cursel_d;
    logic [CHW-1:0] rr_q, rr_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic [8:0]     rem_q, rem_d;
    logic [8:0]     iss_q, iss_d;
    logic           busy_q, busy_d;
    logic           take_q;
    logic [15:0]    dout_q;
    logic           dvalid_q;

    logic [15:0]    din_arr [NCH];
    logic [15:0]    word;
    logic [8:0]     hdr_rem;
    logic           hdr_err;
    logic           hdr_bad;
    logic [NCH-1:0] ack_sel;
    logic           hit, hit_hi;
    logic [CHW-1:0] pick, pick_hi, pick_lo;

    for (genvar g = 0; g < NCH; g++) begin : g_slice
        assign din_arr[g] = din[16*g +: 16];
    end

    assign word    = din_arr[cursel_q];
    assign ack_sel = NCH'(1) << cursel_q;
    // 9 bits so that L=255 plus a trigger word (256) does not wrap.
    assign hdr_rem = {1'b0, word[7:0]} + {8'd0, word[14]};

`ifdef ARB_HDRCHK_EN
    logic [15:0] err_q;
    assign hdr_err = !word[15] || (word[13:8] != 6'(cursel_q));
`else
    assign hdr_err = 1'b0;
`endif

    // Round-robin search starting after rr_q: lowest requester above rr_q
    // wins, otherwise wrap to the lowest requester overall.
    always_comb begin
        hit     = 1'b0;
        hit_hi  = 1'b0;
        pick_hi = '0;
        pick_lo = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                hit     = 1'b1;
                pick_lo = CHW'(i);
                if (CHW'(i) > rr_q) begin
                    hit_hi  = 1'b1;
                    pick_hi = CHW'(i);
                end
            end
        end
        pick = hit_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        state_d  = state_q;
        cursel_d = cursel_q;
        rr_d     = rr_q;
        ack_d    = '0;
        rem_d    = rem_q;
        iss_d    = iss_q;
        busy_d   = busy_q;
        hdr_bad  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    cursel_d = pick;
                    busy_d   = 1'b1;
                    state_d  = S_ACKH;
                end
            end
            S_ACKH: begin
                if (!dafull) begin
                    ack_d   = ack_sel;
                    state_d = S_WAITH;
                end
            end
            S_WAITH: state_d = S_HDR;
            S_HDR: begin
                iss_d = '0;
                rem_d = hdr_rem;
                if (hdr_err) begin
                    hdr_bad = 1'b1;
                    state_d = S_DONE;
                end else if (hdr_rem == 9'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COPY;
                end
            end
            S_COPY: begin
                if (iss_q != rem_q) begin
                    if (!dafull) begin
                        ack_d = ack_sel;
                        iss_d = iss_q + 9'd1;
                    end
                end else if (ack_q == '0) begin
                    // Last ack already retired; its word is being captured now.
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                rr_d    = cursel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cursel_q <= '0;
            rr_q     <= '0;
            ack_q    <= '0;
            rem_q    <= '0;
            iss_q    <= '0;
            busy_q   <= 1'b0;
            take_q   <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursel_q <= cursel_d;
            rr_q     <= rr_d;
            ack_q    <= ack_d;
            rem_q    <= rem_d;
            iss_q    <= iss_d;
            busy_q   <= busy_d;
            // An ack high this cycle puts its word on din next cycle.
            take_q   <= |ack_q;
            dvalid_q <= take_q && !hdr_bad;
            if (take_q && !hdr_bad) begin
                dout_q <= word;
            end
        end
    end

`ifdef ARB_HDRCHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (hdr_bad && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end
    assign err_cnt = err_q;
`else
    assign err_cnt = 16'd0;
`endif

    assign ack    = ack_q;
    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign busy   = busy_q;
    assign cursel = cursel_q;

endmodule

// File: tb/tb_chan_arbiter.sv
module tb_chan_arbiter;
    localparam int NCH = 16;
    localparam int CHW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [16*NCH-1:0] din;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    ack;
    logic [15:0]       dout;
    logic              dvalid;
    logic              dafull;
    logic              busy;
    logic [CHW-1:0]    cursel;
    logic [15:0]       err_cnt;

    chan_arbiter #(.NCH(NCH), .CHW(CHW)) dut (
        .clk(clk), .reset(reset), .din(din), .req(req), .ack(ack),
        .dout(dout), .dvalid(dvalid), .dafull(dafull), .busy(busy),
        .cursel(cursel), .err_cnt(err_cnt)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Channel processor model: per-channel word FIFO, ack pops next word onto din.
    logic [15:0] mem [NCH][1024];
    int          wp  [NCH];
    int          stg [NCH];
    int          rp  [NCH];
    logic [15:0] dslice [NCH];
    logic        chan_clr;

    always_comb begin
        din = '0;
        req = '0;
        for (int i = 0; i < NCH; i++) begin
            din[16*i +: 16] = dslice[i];
            req[i] = (rp[i] < wp[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (chan_clr) rp[i] <= wp[i];
            else if (ack[i] && rp[i] < wp[i]) begin
                dslice[i] <= mem[i][rp[i]];
                rp[i]     <= rp[i] + 1;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [15:0]    olog [4096];
    int             ocnt = 0;
    logic [CHW-1:0] glog [64];
    int             gcnt = 0;
    int             ackcnt [NCH];
    logic           busy_prev = 1'b0;
    logic           daf_prev = 1'b0;
    int             daf_rises = 0;
    int             daf_cur = 0;
    int             daf_max = 0;

    always @(negedge clk) begin
        if (dvalid === 1'b1 && ocnt < 4096) begin
            olog[ocnt] = dout;
            ocnt++;
        end
        for (int i = 0; i < NCH; i++) if (ack[i] === 1'b1) ackcnt[i]++;
        if (busy === 1'b1 && !busy_prev && gcnt < 64) begin
            glog[gcnt] = cursel;
            gcnt++;
        end
        busy_prev = (busy === 1'b1);
        if (dafull && !daf_prev) begin
            daf_rises++;
            daf_cur = 0;
        end else if (dafull && dvalid === 1'b1) begin
            daf_cur++;
            if (daf_cur > daf_max) daf_max = daf_cur;
        end
        daf_prev = dafull;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [15:0] w);
        mem[ch][stg[ch]] = w;
        stg[ch]++;
    endtask

    task automatic commit(input int ch);
        wp[ch] = stg[ch];
    endtask

    task automatic wait_quiet(input string tag, input int maxc);
        int q = 0;
        int n = 0;
        while (q < 3 && n < maxc) begin
            tick();
            n++;
            if (busy === 1'b0 && req == '0 && ack === '0 && dvalid === 1'b0) q++;
            else q = 0;
        end
        check(tag, 32'(q >= 3), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, ab, gb, bad, n;
        logic [15:0] ev;

        for (int i = 0; i < NCH; i++) begin
            wp[i] = 0; stg[i] = 0; rp[i] = 0; ackcnt[i] = 0; dslice[i] = '0;
        end
        reset = 1'b1; dafull = 1'b0; chan_clr = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dvalid", 32'(dvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cursel", 32'(cursel), 32'd0);
        check("rst_errcnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // 1: ch2 header 0x8203 plus three data words
        ob = ocnt; ab = ackcnt[2]; gb = gcnt;
        push(2, 16'h8203); push(2, 16'h1111); push(2, 16'h2222); push(2, 16'h3333);
        commit(2);
        wait_quiet("t1_quiet", 100);
        check("t1_count", 32'(ocnt - ob), 32'd4);
        check("t1_w0", 32'(olog[ob]), 32'h8203);
        check("t1_w1", 32'(olog[ob+1]), 32'h1111);
        check("t1_w2", 32'(olog[ob+2]), 32'h2222);
        check("t1_w3", 32'(olog[ob+3]), 32'h3333);
        check("t1_acks", 32'(ackcnt[2] - ab), 32'd4);
        check("t1_grant", 32'(glog[gb]), 32'd2);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: ch5 header with trigger word, L=2
        ob = ocnt; ab = ackcnt[5];
        push(5, 16'hC502); push(5, 16'h8123); push(5, 16'h0AAA); push(5, 16'h0BBB);
        commit(5);
        wait_quiet("t2_quiet", 100);
        check("t2_count", 32'(ocnt - ob), 32'd4);
        check("t2_w0", 32'(olog[ob]), 32'hC502);
        check("t2_w1", 32'(olog[ob+1]), 32'h8123);
        check("t2_w2", 32'(olog[ob+2]), 32'h0AAA);
        check("t2_w3", 32'(olog[ob+3]), 32'h0BBB);
        check("t2_acks", 32'(ackcnt[5] - ab), 32'd4);

        // 5: L=0 block on ch3
        ob = ocnt; ab = ackcnt[3];
        push(3, 16'h8300); commit(3);
        wait_quiet("t5_quiet", 100);
        check("t5_count", 32'(ocnt - ob), 32'd1);
        check("t5_w0", 32'(olog[ob]), 32'h8300);
        check("t5_acks", 32'(ackcnt[3] - ab), 32'd1);

        // 3: park rr on ch15, then ch0/ch1 three blocks each -> 0,1,0,1,0,1
        push(15, 16'h8F00); commit(15);
        wait_quiet("t3_park", 100);
        ob = ocnt; gb = gcnt;
        for (int k = 0; k < 3; k++) begin
            push(0, 16'h8001); push(0, 16'(16'h0A00 + k));
            push(1, 16'h8101); push(1, 16'(16'h0B00 + k));
        end
        commit(0); commit(1);
        wait_quiet("t3_quiet", 300);
        check("t3_count", 32'(ocnt - ob), 32'd12);
        for (int k = 0; k < 6; k++) check("t3_grant", 32'(glog[gb+k]), 32'(k % 2));
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (olog[ob+4*k]   !== 16'h8001) bad++;
            if (olog[ob+4*k+1] !== 16'(16'h0A00 + k)) bad++;
            if (olog[ob+4*k+2] !== 16'h8101) bad++;
            if (olog[ob+4*k+3] !== 16'(16'h0B00 + k)) bad++;
        end
        check("t3_words", 32'(bad), 32'd0);

        // 4: two max-size blocks (rem=256) with dafull toggling every 7 cycles
        ob = ocnt; ab = ackcnt[0];
        for (int b = 0; b < 2; b++) begin
            push(0, 16'hC0FF);
            for (int j = 0; j < 256; j++) push(0, 16'(16'h1000 * (b + 1) + j));
        end
        commit(0);
        n = 0;
        while (n < 4000 && !(n > 10 && busy === 1'b0 && req == '0 && dvalid === 1'b0)) begin
            tick();
            n++;
            if (n % 7 == 0) dafull = ~dafull;
        end
        dafull = 1'b0;
        check("t4_finish", 32'(n < 4000), 32'd1);
        wait_quiet("t4_quiet", 100);
        check("t4_count", 32'(ocnt - ob), 32'd514);
        check("t4_acks", 32'(ackcnt[0] - ab), 32'd514);
        bad = 0;
        for (int b = 0; b < 2; b++) begin
            if (olog[ob + 257*b] !== 16'hC0FF) bad++;
            for (int j = 0; j < 256; j++) begin
                ev = 16'(16'h1000 * (b + 1) + j);
                if (olog[ob + 257*b + 1 + j] !== ev) bad++;
            end
        end
        check("t4_words", 32'(bad), 32'd0);
        check("t4_daf_rises", 32'(daf_rises > 0), 32'd1);
        check("t4_daf_after", 32'(daf_max <= 2), 32'd1);

        // 6: ch4 header 0x0404 (bit15 clear)
        ob = ocnt;
        push(4, 16'h0404);
`ifndef ARB_HDRCHK_EN
        for (int j = 0; j < 4; j++) push(4, 16'(16'h4440 + j));
`endif
        commit(4);
        wait_quiet("t6_quiet", 100);
`ifdef ARB_HDRCHK_EN
        check("t6_count", 32'(ocnt - ob), 32'd0);
        check("t6_errcnt", 32'(err_cnt), 32'd1);
`else
        check("t6_count", 32'(ocnt - ob), 32'd5);
        check("t6_w0", 32'(olog[ob]), 32'h0404);
        check("t6_w4", 32'(olog[ob+4]), 32'h4443);
        check("t6_errcnt", 32'(err_cnt), 32'd0);
`endif

        // Reset in the middle of a COPY phase
        ab = ackcnt[6];
        push(6, 16'h8608);
        for (int j = 0; j < 8; j++) push(6, 16'(16'h6600 + j));
        commit(6);
        n = 0;
        while (n < 100 && ackcnt[6] - ab < 3) begin
            tick();
            n++;
        end
        check("t6_copy_reached", 32'(n < 100), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_ack", 32'(ack), 32'd0);
        check("t6_rst_dvalid", 32'(dvalid), 32'd0);
        check("t6_rst_errcnt", 32'(err_cnt), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_dout", 32'(dout), 32'd0);
        chan_clr = 1'b1;
        tick();
        chan_clr = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Fresh block after reset: rr restarts at 0 so ch1 is found first
        ob = ocnt; gb = gcnt;
        push(1, 16'h8101); push(1, 16'h7777); commit(1);
        wait_quiet("t7_quiet", 100);
        check("t7_count", 32'(ocnt - ob), 32'd2);
        check("t7_w1", 32'(olog[ob+1]), 32'h7777);
        check("t7_grant", 32'(glog[gb]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
